instr_encoder: RTL
==================

# instr_encoder

Streaming RV32I instruction encoder: the inverse of the control unit's decode path. Accepts ALU-operation requests (ALU op code, register indices, optional immediate), encodes each into a 32-bit R-type or I-type word using the same ALUOp code points the control unit decodes, buffers them in a small FIFO, and writes them sequentially into instruction memory through a valid/ready write port. Used by the test harness and boot loader to generate instruction streams for the core.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2)
- ADDR_W, 10: instruction-memory word-address width
- BASE_ADDR, 0: first write address after reset/flush

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard FIFO contents, reload address to BASE_ADDR
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept; high iff FIFO not full and flush low
- req_alu_op  in  4  ALUOp code (same encoding as control unit)
- req_rd / req_rs1 / req_rs2  in  5 each  register indices
- req_imm_en  in  1  1: I-type (OP-IMM), 0: R-type (OP)
- req_imm  in  12  immediate, I-type only
- req_err  out  1  one-cycle pulse: previous accepted request was illegal and dropped
- im_wr_en  out  1  write valid (FIFO non-empty)
- im_wr_ready  in  1  memory accepts write
- im_wr_addr  out  ADDR_W  word address of current write
- im_wr_data  out  32  encoded instruction
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Accept on req_valid && req_ready; encode combinationally, push encoded word same edge.
- ALUOp map (funct3/funct7): 0000 AND 7/0; 0001 OR 6/0; 0010 ADD 0/0; 0011 SLL 1/0; 0100 SUB 0/0x20; 0101 SRL 5/0; 0110 SLT 2/0; 0111 XOR 4/0.
- R-type: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- I-type: {req_imm, rs1, funct3, rd, 7'b0010011}; SLL/SRL: bits[31:25]=0, bits[24:20]=req_imm[4:0], req_imm[11:5] ignored.
- Illegal (consumed, not pushed, req_err pulses next cycle): ALUOp ≥ 1000; SUB with req_imm_en=1.
- Write side: im_wr_en = !empty; on im_wr_en && im_wr_ready pop head, im_wr_addr increments by 1, wraps modulo 2^ADDR_W.
- Stall (im_wr_en && !im_wr_ready): addr and data held stable.
- Simultaneous push and pop: count unchanged; push into full FIFO impossible (req_ready low); no empty-to-output bypass.
- flush: highest priority after rst; same edge empties FIFO, address=BASE_ADDR, suppresses push, clears pending req_err; a pop in the flush cycle is discarded (address not advanced).

## Timing
- Reset values: req_ready=0 during rst, 1 the cycle after; im_wr_en=0, im_wr_addr=BASE_ADDR, im_wr_data=0, req_err=0, count=0.
- Latency: request accepted at edge N → im_wr_en high cycle after N with encoded word.
- Throughput: one request and one write per cycle sustained.
- req_err registered: asserted exactly one cycle, cycle after illegal acceptance.
- rst mid-stream: all queued words lost, no partial write.
- All outputs registered or driven from registered state; no combinational path req_* → im_wr_*.

## Structure
- Shared package rv_isa_pkg: OP_R=7'b0110011, OP_I=7'b0010011, alu_op_e enum (8 codes above), funct3/funct7 constants; control unit adopts same package.
- Sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count); encoder logic as a function in the top.

## Test plan
- ADD rd=3 rs1=1 rs2=2, im_wr_ready=1 → one write, addr 0, data 0x002081B3, next cycle.
- SUB rd=5 rs1=6 rs2=7 then ADDI (op 0010, imm 0xFFF, rd=1, rs1=0) back-to-back → addr 0: 0x407302B3, addr 1: 0xFFF00093.
- ALUOp 4'b1000 and SUB with req_imm_en=1 → req_err pulses one cycle each, no write, address unchanged.
- im_wr_ready=0, 5 requests offered → 4 accepted, req_ready low, count=4; release → 4 writes in order, addresses 0–3, then 5th accepted.
- ADDR_W=2, 5 requests → addresses 0,1,2,3,0.
- flush with 3 queued, im_wr_ready=0 → count=0, im_wr_en=0 next cycle; next request written at BASE_ADDR.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I opcodes, ALUOp code points and funct fields shared by the encoder and the control unit
package rv_isa_pkg;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_XOR = 4'b0111
  } alu_op_e;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SRL = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;
  typedef struct packed {
    logic        illegal;
    logic [31:0] word;
  } enc_t;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request stream in, instruction-memory write port out
interface instr_encoder_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_alu_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic              req_imm_en;
  logic [11:0]       req_imm;
  logic              req_err;
  logic              im_wr_en;
  logic              im_wr_ready;
  logic [ADDR_W-1:0] im_wr_addr;
  logic [31:0]       im_wr_data;
  modport master (
    output req_valid, req_alu_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm, im_wr_ready,
    input  req_ready, req_err, im_wr_en, im_wr_addr, im_wr_data
  );
  modport slave (
    input  req_valid, req_alu_op, req_rd, req_rs1, req_rs2, req_imm_en, req_imm, im_wr_ready,
    output req_ready, req_err, im_wr_en, im_wr_addr, im_wr_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with flush, full/empty flags and occupancy count
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  // storage write; contents beyond the pointers are don't-care so no reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers and occupancy; flush empties exactly like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes ALUOp requests into RV32I R/I-type words and streams them into instruction memory
module instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  instr_encoder_if.slave         bus,
  output logic [$clog2(DEPTH):0] count
);
  function automatic enc_t encode(input logic [3:0] op, input logic [4:0] rd, rs1, rs2,
                                  input logic imm_en, input logic [11:0] imm);
    enc_t       e;
    logic [2:0] f3;
    case (op)
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_SLL: f3 = F3_SLL;
      ALU_SRL: f3 = F3_SRL;
      ALU_SLT: f3 = F3_SLT;
      ALU_XOR: f3 = F3_XOR;
      default: f3 = F3_ADD;
    endcase
    e.illegal = op[3] || (op == ALU_SUB && imm_en);
    e.word = !imm_en ? {(op == ALU_SUB) ? F7_SUB : F7_BASE, rs2, rs1, f3, rd, OP_R}
           : (op == ALU_SLL || op == ALU_SRL) ? {F7_BASE, imm[4:0], rs1, f3, rd, OP_I}
           : {imm, rs1, f3, rd, OP_I};
    return e;
  endfunction
  enc_t              enc;
  logic              accept, push, pop, full, empty, err_q;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr;
  assign enc    = encode(bus.req_alu_op, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm_en, bus.req_imm);
  assign bus.req_ready = !rst && !flush && !full;
  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && !enc.illegal;
  assign pop    = !empty && bus.im_wr_ready;
  sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (enc.word),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // write address advances once per completed write; a pop under flush is discarded
  always_ff @(posedge clk)
    addr <= (rst || flush) ? BASE_ADDR : pop ? addr + 1'b1 : addr;
  // illegal requests are consumed and reported one cycle later
  always_ff @(posedge clk)
    err_q <= !rst && !flush && accept && enc.illegal;
  assign bus.req_err    = err_q;
  assign bus.im_wr_en   = !empty;
  assign bus.im_wr_addr = addr;
  assign bus.im_wr_data = empty ? 32'h0 : head;
endmodule
